// File: rtl/ann_pkg.sv
// Shared constants and types for the ANN RAM read path.
//   ADDR_WIDTH : RAM address width
//   RAM_PORT   : RAM port word width
//   RAM_WORDS  : number of RAM words
//   rd_state_e : read-master FSM states
package ann_pkg;

  localparam int ADDR_WIDTH = 8;
  localparam int RAM_PORT   = 16;
  localparam int RAM_WORDS  = 1 << ADDR_WIDTH;

  typedef enum logic [1:0] {
    RD_IDLE  = 2'd0,
    RD_RUN   = 2'd1,
    RD_DRAIN = 2'd2
  } rd_state_e;

endpackage : ann_pkg

// File: rtl/ann_rd_fifo.sv
// Small synchronous FIFO buffering words read from the ANN RAM.
// Ports:
//   clk_i, rst_n_i : clock, asynchronous active-low reset
//   flush_i        : empties the FIFO (wins over push/pop)
//   push_i, push_data_i : write one word
//   pop_i          : drop the head word (caller only pops when not empty)
//   pop_data_o     : head word
//   count_o        : occupancy
//   empty_o        : occupancy is zero
// Push and pop in the same cycle are allowed, also when full.
module ann_rd_fifo #(
  parameter  int WIDTH = 16,
  parameter  int DEPTH = 3,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] pop_data_o,
  output logic [CNT_W-1:0] count_o,
  output logic             empty_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  // Pointers wrap explicitly because DEPTH need not be a power of two.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_i) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (pop_i)  rd_ptr_d = ptr_inc(rd_ptr_q);
      case ({push_i, pop_i})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is not reset; emptiness is tracked by count_q, so stale contents are never observed.
  always_ff @(posedge clk_i) begin
    if (push_i && !flush_i) mem_q[wr_ptr_q] <= push_data_i;
  end

  assign pop_data_o = mem_q[rd_ptr_q];
  assign count_o    = count_q;
  assign empty_o    = (count_q == '0);

endmodule : ann_rd_fifo

// File: rtl/ann_ram_reader.sv
// Read-side master for the single-port ANN weight/activation RAM.
// A block-read command (base_addr_i, length_i) is turned into sequential
// read addresses; each word arrives one cycle after its address and is
// buffered in a FIFO that feeds a valid/ready stream.
// Ports:
//   clk_i, rst_n_i           : clock, asynchronous active-low reset
//   start_i, base_addr_i, length_i : command (sampled in IDLE only)
//   busy_o, done_o           : command status; done_o is a one-cycle pulse
//   ram_wr_e_o, ram_addr_o, ram_data_i : RAM read port (registered read)
//   data_o, valid_o, ready_i, last_o   : output stream
//   abort_i                  : only with ANN_RAM_READER_ABORT_EN defined;
//                              cancels a running command without done_o
module ann_ram_reader #(
  parameter int ADDR_WIDTH = ann_pkg::ADDR_WIDTH,
  parameter int DATA_WIDTH = ann_pkg::RAM_PORT,
  parameter int LEN_WIDTH  = ADDR_WIDTH + 1,
  parameter int FIFO_DEPTH = 3
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  start_i,
  input  logic [ADDR_WIDTH-1:0] base_addr_i,
  input  logic [LEN_WIDTH-1:0]  length_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  ram_wr_e_o,
  output logic [ADDR_WIDTH-1:0] ram_addr_o,
  input  logic [DATA_WIDTH-1:0] ram_data_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  valid_o,
`ifdef ANN_RAM_READER_ABORT_EN
  input  logic                  abort_i,
`endif
  input  logic                  ready_i,
  output logic                  last_o
);

  import ann_pkg::*;

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [CNT_W:0]          DEPTH_LIM = (CNT_W + 1)'(FIFO_DEPTH);
  localparam logic [ADDR_WIDTH-1:0]   ADDR_ONE  = ADDR_WIDTH'(1);
  localparam logic [LEN_WIDTH-1:0]    LEN_ONE   = LEN_WIDTH'(1);

  if (FIFO_DEPTH < 3) begin : g_depth_check
    $error("ann_ram_reader: FIFO_DEPTH must be at least 3");
  end

  rd_state_e             state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH-1:0] last_addr_q, last_addr_d;
  logic [LEN_WIDTH-1:0]  issue_cnt_q, issue_cnt_d;
  logic [LEN_WIDTH-1:0]  pop_cnt_q, pop_cnt_d;
  logic                  pend_q, pend_d;
  logic                  done_q, done_d;

  logic                  issue;
  logic                  pop;
  logic                  room;
  logic                  flush;
  logic                  fifo_empty;
  logic [CNT_W-1:0]      fifo_count;
  logic [DATA_WIDTH-1:0] fifo_head;

  assign pop = !fifo_empty && ready_i;

  // Room is judged on registered occupancy plus the read still in flight;
  // a same-cycle pop is deliberately not credited, which keeps ready_i out
  // of the address path.
  assign room = ({1'b0, fifo_count} + {{CNT_W{1'b0}}, pend_q}) < DEPTH_LIM;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    last_addr_d = last_addr_q;
    issue_cnt_d = issue_cnt_q;
    pop_cnt_d   = pop_cnt_q;
    pend_d      = 1'b0;
    done_d      = 1'b0;
    issue       = 1'b0;
    flush       = 1'b0;

    case (state_q)
      RD_IDLE: begin
        // The done_o cycle is already IDLE; a start there is dropped.
        if (start_i && !done_q) begin
          if (length_i != '0) begin
            state_d     = RD_RUN;
            addr_d      = base_addr_i;
            issue_cnt_d = length_i;
            pop_cnt_d   = length_i;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      RD_RUN: begin
        if (issue_cnt_q != '0 && room) begin
          issue       = 1'b1;
          pend_d      = 1'b1;
          last_addr_d = addr_q;
          addr_d      = addr_q + ADDR_ONE;
          issue_cnt_d = issue_cnt_q - LEN_ONE;
          if (issue_cnt_q == LEN_ONE) state_d = RD_DRAIN;
        end
      end
      RD_DRAIN: begin
        state_d = RD_DRAIN;
      end
      default: state_d = RD_IDLE;
    endcase

    if (pop) begin
      pop_cnt_d = pop_cnt_q - LEN_ONE;
      if (pop_cnt_q == LEN_ONE) begin
        done_d  = 1'b1;
        state_d = RD_IDLE;
      end
    end

`ifdef ANN_RAM_READER_ABORT_EN
    if (abort_i && state_q != RD_IDLE) begin
      state_d     = RD_IDLE;
      flush       = 1'b1;
      pend_d      = 1'b0;
      done_d      = 1'b0;
      issue_cnt_d = '0;
      pop_cnt_d   = '0;
    end
`endif
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= RD_IDLE;
      addr_q      <= '0;
      last_addr_q <= '0;
      issue_cnt_q <= '0;
      pop_cnt_q   <= '0;
      pend_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      last_addr_q <= last_addr_d;
      issue_cnt_q <= issue_cnt_d;
      pop_cnt_q   <= pop_cnt_d;
      pend_q      <= pend_d;
      done_q      <= done_d;
    end
  end

  // pend_q marks the cycle in which ram_data_i carries the word addressed
  // one cycle earlier.
  ann_rd_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i       (clk_i),
    .rst_n_i     (rst_n_i),
    .flush_i     (flush),
    .push_i      (pend_q),
    .push_data_i (ram_data_i),
    .pop_i       (pop),
    .pop_data_o  (fifo_head),
    .count_o     (fifo_count),
    .empty_o     (fifo_empty)
  );

  assign busy_o     = (state_q != RD_IDLE);
  assign done_o     = done_q;
  assign ram_wr_e_o = 1'b0;
  assign ram_addr_o = issue ? addr_q : last_addr_q;
  assign valid_o    = !fifo_empty;
  // Gate the head so the stream reads 0 when empty, not stale storage.
  assign data_o     = fifo_empty ? '0 : fifo_head;
  assign last_o     = !fifo_empty && (pop_cnt_q == LEN_ONE);

endmodule : ann_ram_reader

// File: tb/tb_ann_ram_reader.sv
// Self-checking bench for ann_ram_reader: behavioural RAM with
// mem[i] = i + 0x100, a table of block-read vectors, and hand-written
// sequences for zero length, reset mid-transfer and (optionally) abort.
module tb_ann_ram_reader;

  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic        start_i;
  logic [7:0]  base_addr_i;
  logic [8:0]  length_i;
  logic        busy_o;
  logic        done_o;
  logic        ram_wr_e_o;
  logic [7:0]  ram_addr_o;
  logic [15:0] ram_data_i;
  logic [15:0] data_o;
  logic        valid_o;
  logic        ready_i;
  logic        last_o;
`ifdef ANN_RAM_READER_ABORT_EN
  logic        abort_i;
`endif

  int checks = 0;
  int errors = 0;

  logic [15:0] mem [256];

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) ram_data_i <= mem[ram_addr_o];

  ann_ram_reader dut (
    .clk_i       (clk_i),
    .rst_n_i     (rst_n_i),
    .start_i     (start_i),
    .base_addr_i (base_addr_i),
    .length_i    (length_i),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .ram_wr_e_o  (ram_wr_e_o),
    .ram_addr_o  (ram_addr_o),
    .ram_data_i  (ram_data_i),
    .data_o      (data_o),
    .valid_o     (valid_o),
`ifdef ANN_RAM_READER_ABORT_EN
    .abort_i     (abort_i),
`endif
    .ready_i     (ready_i),
    .last_o      (last_o)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [7:0]  base;
    logic [8:0]  len;
    bit          rnd;
    bit          poke;
    logic [15:0] exp_first;
    logic [15:0] exp_last;
    int          exp_done;
  } vec_t;

  // Runs one command; start_i is sampled at edge 0, cycle k is the
  // interval after edge k-1. Collects stream statistics for the caller.
  task automatic run_xfer(input vec_t v,
                          output int got, output int issued,
                          output int order_err, output int last_err,
                          output int issue_err, output int wr_err,
                          output int done_cyc, output int first_cyc,
                          output logic [15:0] first_d, output logic [15:0] last_d);
    logic [7:0]  next_addr;
    logic [7:0]  a;
    logic [15:0] exp;
    got = 0; issued = 0; order_err = 0; last_err = 0; issue_err = 0; wr_err = 0;
    done_cyc = -1; first_cyc = -1; first_d = '0; last_d = '0;
    next_addr = v.base;
    @(posedge clk_i); #1;
    start_i = 1'b1; base_addr_i = v.base; length_i = v.len;
    ready_i = v.rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    for (int cyc = 1; cyc <= 300 && done_cyc < 0; cyc++) begin
      @(negedge clk_i);
      if (ram_wr_e_o !== 1'b0) wr_err++;
      if (busy_o && issued < int'(v.len) && ram_addr_o == next_addr) begin
        if (issued - got >= 3) issue_err++;
        issued++;
        next_addr = next_addr + 8'd1;
      end
      if (done_o) done_cyc = cyc;
      if (valid_o && first_cyc < 0) first_cyc = cyc;
      if (valid_o && ready_i) begin
        a   = v.base + got[7:0];
        exp = {8'h01, a};
        if (data_o !== exp) order_err++;
        if (last_o !== (got == int'(v.len) - 1)) last_err++;
        if (got == 0) first_d = data_o;
        last_d = data_o;
        got++;
      end
      @(posedge clk_i); #1;
      ready_i = v.rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      start_i = v.poke && (cyc == 1 || cyc == int'(v.len) + 2);
      if (start_i) begin
        base_addr_i = 8'h80;
        length_i    = 9'd2;
      end
    end
    start_i = 1'b0;
  endtask

  task automatic apply_vec(input vec_t v, input string tag);
    int got, issued, order_err, last_err, issue_err, wr_err, done_cyc, first_cyc;
    logic [15:0] first_d, last_d;
    run_xfer(v, got, issued, order_err, last_err, issue_err, wr_err,
             done_cyc, first_cyc, first_d, last_d);
    check({tag, " done_seen"}, done_cyc >= 0, 1);
    check({tag, " word_count"}, got, v.len);
    check({tag, " issue_count"}, issued, v.len);
    check({tag, " data_order"}, order_err, 0);
    check({tag, " last_flag"}, last_err, 0);
    check({tag, " occupancy_limit"}, issue_err, 0);
    check({tag, " wr_e_low"}, wr_err, 0);
    check({tag, " first_data"}, first_d, v.exp_first);
    check({tag, " last_data"}, last_d, v.exp_last);
    if (!v.rnd) begin
      check({tag, " first_valid_cycle"}, first_cyc, 3);
      check({tag, " done_cycle"}, done_cyc, v.exp_done);
    end
    @(negedge clk_i);
    check({tag, " idle_after_done"}, busy_o, 0);
    check({tag, " done_one_cycle"}, done_o, 0);
    check({tag, " valid_after_done"}, valid_o, 0);
  endtask

  vec_t vecs[6];

  initial begin
    logic [7:0] held;
    int popped;
    vec_t v;

    for (int i = 0; i < 256; i++) mem[i] = 16'h0100 + 16'(i);

    //         base   len  rnd poke first     last      done
    vecs[0] = '{8'h10, 9'd4, 0, 0, 16'h0110, 16'h0113, 7};
    vecs[1] = '{8'hFE, 9'd4, 0, 0, 16'h01FE, 16'h0101, 7};
    vecs[2] = '{8'h20, 9'd8, 1, 0, 16'h0120, 16'h0127, -1};
    vecs[3] = '{8'h00, 9'd1, 0, 0, 16'h0100, 16'h0100, 4};
    vecs[4] = '{8'h7F, 9'd3, 0, 0, 16'h017F, 16'h0181, 6};
    vecs[5] = '{8'h40, 9'd4, 0, 1, 16'h0140, 16'h0143, 7};

    rst_n_i = 1'b0; start_i = 1'b0; base_addr_i = '0; length_i = '0; ready_i = 1'b1;
`ifdef ANN_RAM_READER_ABORT_EN
    abort_i = 1'b0;
`endif
    #3;
    check("reset busy_o", busy_o, 0);
    check("reset done_o", done_o, 0);
    check("reset valid_o", valid_o, 0);
    check("reset last_o", last_o, 0);
    check("reset data_o", data_o, 0);
    check("reset ram_addr_o", ram_addr_o, 0);
    check("reset ram_wr_e_o", ram_wr_e_o, 0);
    @(posedge clk_i); #1; rst_n_i = 1'b1;

    // Zero-length command: done one cycle later, nothing else moves.
    @(negedge clk_i); held = ram_addr_o;
    @(posedge clk_i); #1; start_i = 1'b1; base_addr_i = 8'h55; length_i = 9'd0;
    @(posedge clk_i); #1; start_i = 1'b0;
    @(negedge clk_i);
    check("zero_len done_o", done_o, 1);
    check("zero_len busy_o", busy_o, 0);
    check("zero_len valid_o", valid_o, 0);
    check("zero_len ram_addr_o", ram_addr_o, held);
    @(negedge clk_i);
    check("zero_len done_clear", done_o, 0);
    check("zero_len ram_addr_hold", ram_addr_o, held);

    for (int i = 0; i < 6; i++) apply_vec(vecs[i], $sformatf("vec%0d", i));

    // Reset mid-transfer after 2 of 6 words popped.
    @(posedge clk_i); #1; start_i = 1'b1; base_addr_i = 8'h30; length_i = 9'd6; ready_i = 1'b1;
    @(posedge clk_i); #1; start_i = 1'b0;
    popped = 0;
    for (int cyc = 1; cyc <= 20 && popped < 2; cyc++) begin
      @(negedge clk_i);
      if (valid_o && ready_i) popped++;
    end
    check("midreset popped", popped, 2);
    #2 rst_n_i = 1'b0;
    #1;
    check("midreset busy_o", busy_o, 0);
    check("midreset valid_o", valid_o, 0);
    check("midreset data_o", data_o, 0);
    check("midreset last_o", last_o, 0);
    check("midreset ram_addr_o", ram_addr_o, 0);
    check("midreset done_o", done_o, 0);
    @(posedge clk_i); #1; rst_n_i = 1'b1;
    repeat (3) begin
      @(negedge clk_i);
      check("midreset stays idle", {busy_o, valid_o, done_o}, 0);
    end
    v = '{8'h00, 9'd2, 0, 0, 16'h0100, 16'h0101, 5};
    apply_vec(v, "after_reset");

`ifdef ANN_RAM_READER_ABORT_EN
    // Abort after 3 of 8 words.
    @(posedge clk_i); #1; start_i = 1'b1; base_addr_i = 8'h50; length_i = 9'd8; ready_i = 1'b1;
    @(posedge clk_i); #1; start_i = 1'b0;
    popped = 0;
    for (int cyc = 1; cyc <= 20 && popped < 3; cyc++) begin
      @(negedge clk_i);
      if (valid_o && ready_i) popped++;
    end
    check("abort popped", popped, 3);
    @(posedge clk_i); #1; abort_i = 1'b1;
    @(posedge clk_i); #1; abort_i = 1'b0;
    @(negedge clk_i);
    check("abort valid_o", valid_o, 0);
    check("abort busy_o", busy_o, 0);
    repeat (4) begin
      check("abort no done", done_o, 0);
      @(negedge clk_i);
    end
    v = '{8'h60, 9'd2, 0, 0, 16'h0160, 16'h0161, 5};
    apply_vec(v, "after_abort");
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_ann_ram_reader
